// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers hex nibbles and decimal points from a
// time-multiplexed, active-low seven-segment bus (shared segments + digit enables).
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   seg_n[7:0]   segment bus, active-low; bit7 = DP, bits[6:0] = g..a
//   dig_n        per-digit enables, active-low; one bit low = valid scan slot
//   value        decoded nibbles, digit i at [4i+3:4i]
//   dp           decimal point per digit, 1 = lit
//   digit_ok     1 = last committed pattern for that digit was a legal hex code
//   frame_valid  one-cycle pulse once every digit has committed since the last pulse
//   err          one-cycle pulse on an illegal pattern or a multi-hot dig_n
//
// Build option: define SEG7_SYNC_EN to put a 2-flop synchronizer (reset to
// all-ones) on seg_n and dig_n; every latency then grows by 2 cycles.
module seg7_scan_decoder #(
    parameter int DIGITS = 4,
    parameter int SETTLE = 4,
    parameter int STABLE = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            seg_n,
    input  logic [DIGITS-1:0]     dig_n,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     dp,
    output logic [DIGITS-1:0]     digit_ok,
    output logic                  frame_valid,
    output logic                  err
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = $clog2(SETTLE) + 1;
    localparam int MW = $clog2(STABLE) + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_COMMIT,
        ST_HOLD
    } state_t;

    // ------------------------------------------------------------------
    // Input stage
    // ------------------------------------------------------------------
    logic [7:0]        seg_s;
    logic [DIGITS-1:0] dig_s;

`ifdef SEG7_SYNC_EN
    logic [7:0]        seg_m;
    logic [DIGITS-1:0] dig_m;

    // Idle level of both buses is all-ones, so the synchronizer resets there
    // and never fakes a slot out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_m <= '1;
            seg_s <= '1;
            dig_m <= '1;
            dig_s <= '1;
        end else begin
            seg_m <= seg_n;
            seg_s <= seg_m;
            dig_m <= dig_n;
            dig_s <= dig_m;
        end
    end
`else
    assign seg_s = seg_n;
    assign dig_s = dig_n;
`endif

    // ------------------------------------------------------------------
    // Segment pattern decode: returns {legal, nibble}
    // ------------------------------------------------------------------
    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] r;
        r = 5'b0_0000;
        case (s)
            7'h40:   r = {1'b1, 4'h0};
            7'h79:   r = {1'b1, 4'h1};
            7'h24:   r = {1'b1, 4'h2};
            7'h30:   r = {1'b1, 4'h3};
            7'h19:   r = {1'b1, 4'h4};
            7'h12:   r = {1'b1, 4'h5};
            7'h02:   r = {1'b1, 4'h6};
            7'h78:   r = {1'b1, 4'h7};
            7'h00:   r = {1'b1, 4'h8};
            7'h10:   r = {1'b1, 4'h9};
            7'h08:   r = {1'b1, 4'hA};
            7'h03:   r = {1'b1, 4'hB};
            7'h46:   r = {1'b1, 4'hC};
            7'h21:   r = {1'b1, 4'hD};
            7'h06:   r = {1'b1, 4'hE};
            7'h0E:   r = {1'b1, 4'hF};
            default: r = 5'b0_0000;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Digit-enable classification
    // ------------------------------------------------------------------
    logic [DIGITS-1:0] act;
    logic              one_hot;
    logic              multi_hot;
    logic [IW-1:0]     hot_idx;

    assign act = ~dig_s;

    // Clearing the lowest set bit leaves zero only for a single set bit.
    assign one_hot   = (act != '0) && ((act & (act - DIGITS'(1))) == '0);
    assign multi_hot = (act != '0) && !one_hot;

    always_comb begin
        hot_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (act[i]) begin
                hot_idx = IW'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t            state, state_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic [MW-1:0]     match, match_d;
    logic [7:0]        prev, prev_d;
    logic [IW-1:0]     idx, idx_d;
    logic [DIGITS-1:0] lat, lat_d;
    logic [DIGITS-1:0] seen, seen_d;
    logic              mh, mh_d;
    logic [4*DIGITS-1:0] value_d;
    logic [DIGITS-1:0] dp_d;
    logic [DIGITS-1:0] digit_ok_d;
    logic              frame_valid_d;
    logic              err_d;
    logic [4:0]        dec;

    assign dec = decode(prev[6:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            match       <= '0;
            prev        <= '0;
            idx         <= '0;
            lat         <= '1;
            seen        <= '0;
            mh          <= 1'b0;
            value       <= '0;
            dp          <= '0;
            digit_ok    <= '0;
            frame_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            match       <= match_d;
            prev        <= prev_d;
            idx         <= idx_d;
            lat         <= lat_d;
            seen        <= seen_d;
            mh          <= mh_d;
            value       <= value_d;
            dp          <= dp_d;
            digit_ok    <= digit_ok_d;
            frame_valid <= frame_valid_d;
            err         <= err_d;
        end
    end

    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        match_d       = match;
        prev_d        = prev;
        idx_d         = idx;
        lat_d         = lat;
        seen_d        = seen;
        mh_d          = 1'b0;
        value_d       = value;
        dp_d          = dp;
        digit_ok_d    = digit_ok;
        frame_valid_d = 1'b0;
        err_d         = 1'b0;

        unique case (state)
            ST_IDLE: begin
                // mh remembers a multi-hot bus so err fires only on entry.
                mh_d = multi_hot;
                if (one_hot) begin
                    idx_d   = hot_idx;
                    lat_d   = dig_s;
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end else if (multi_hot && !mh) begin
                    err_d = 1'b1;
                end
            end

            ST_SETTLE: begin
                if (dig_s != lat) begin
                    state_d = ST_IDLE;
                end else if (cnt == CW'(SETTLE - 1)) begin
                    match_d = '0;
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end

            ST_SAMPLE: begin
                if (dig_s != lat) begin
                    state_d = ST_IDLE;
                end else begin
                    prev_d = seg_s;
                    // A changed pattern restarts the run instead of aborting.
                    if ((match == '0) || (seg_s != prev)) begin
                        match_d = MW'(1);
                    end else begin
                        match_d = match + MW'(1);
                    end
                    if (match_d >= MW'(STABLE)) begin
                        state_d = ST_COMMIT;
                    end
                end
            end

            ST_COMMIT: begin
                dp_d[idx]       = ~prev[7];
                digit_ok_d[idx] = dec[4];
                if (dec[4]) begin
                    value_d[idx*4 +: 4] = dec[3:0];
                end else begin
                    err_d = 1'b1;
                end
                seen_d[idx] = 1'b1;
                if (&seen_d) begin
                    frame_valid_d = 1'b1;
                    seen_d        = '0;
                end
                state_d = ST_HOLD;
            end

            ST_HOLD: begin
                if (dig_s != lat) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: directed and randomized scan slots checked against
// a slot-level reference model of the decoder.
module tb_seg7_scan_decoder;

    localparam int DIGITS = 4;
    localparam int SETTLE = 4;
    localparam int STABLE = 2;
`ifdef SEG7_SYNC_EN
    localparam int SD = 2;
`else
    localparam int SD = 0;
`endif
    // Shortest slot that commits, and edge of the commit relative to slot start.
    localparam int NMIN = SETTLE + STABLE + 1;
    localparam int LAT  = NMIN + SD;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [7:0]          seg_n = '1;
    logic [DIGITS-1:0]   dig_n = '1;
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   digit_ok;
    logic                frame_valid;
    logic                err;

    seg7_scan_decoder #(
        .DIGITS (DIGITS),
        .SETTLE (SETTLE),
        .STABLE (STABLE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_n       (seg_n),
        .dig_n       (dig_n),
        .value       (value),
        .dp          (dp),
        .digit_ok    (digit_ok),
        .frame_valid (frame_valid),
        .err         (err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int fvc   = 0;

    logic [6:0] codes [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                               7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                               7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model: what the display should show, per digit.
    logic [3:0]        mval [DIGITS];
    logic [DIGITS-1:0] mdp;
    logic [DIGITS-1:0] mok;
    logic [DIGITS-1:0] mseen;

    function automatic logic [4:0] lookup(input logic [6:0] s);
        for (int k = 0; k < 16; k++) begin
            if (codes[k] == s) return {1'b1, 4'(k)};
        end
        return 5'b0;
    endfunction

    function automatic logic [4*DIGITS-1:0] mvalue();
        logic [4*DIGITS-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) r[i*4 +: 4] = mval[i];
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DIGITS; i++) mval[i] = 4'h0;
        mdp   = '0;
        mok   = '0;
        mseen = '0;
    endtask

    task automatic model_commit(input int d, input logic [7:0] s,
                                output logic xe, output logic xf);
        logic [4:0] lk;
        lk     = lookup(s[6:0]);
        mdp[d] = ~s[7];
        mok[d] = lk[4];
        if (lk[4]) mval[d] = lk[3:0];
        xe       = !lk[4];
        mseen[d] = 1'b1;
        xf       = &mseen;
        if (xf) mseen = '0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic xe, input logic xf);
        if (frame_valid === 1'b1) fvc++;
        check({tag, " value"},    32'(value),       32'(mvalue()));
        check({tag, " dp"},       32'(dp),          32'(mdp));
        check({tag, " digit_ok"}, 32'(digit_ok),    32'(mok));
        check({tag, " err"},      32'(err),         32'(xe));
        check({tag, " frame"},    32'(frame_valid), 32'(xf));
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        dig_n = '1;
        seg_n = '1;
        tick();
        model_clear();
        check_all("reset", 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    // One scan slot preceded by a blanking cycle; runs at least to the
    // commit edge so delayed commits are still observed.
    task automatic slot(input int d, input logic [7:0] s, input int n);
        logic xe, xf, com;
        int   len;
        dig_n = '1;
        seg_n = '1;
        tick();
        check_all("blank", 1'b0, 1'b0);
        com = (n >= NMIN);
        len = (n > LAT + 1) ? n : LAT + 1;
        for (int e = 0; e < len; e++) begin
            if (e < n) begin
                dig_n = ~(DIGITS'(1) << d);
                seg_n = s;
            end else begin
                dig_n = '1;
                seg_n = '1;
            end
            tick();
            xe = 1'b0;
            xf = 1'b0;
            if (com && e == LAT) model_commit(d, s, xe, xf);
            check_all($sformatf("slot d%0d s%02h n%0d e%0d", d, s, n, e), xe, xf);
        end
    endtask

    task automatic multihot(input logic [DIGITS-1:0] pat, input int n);
        dig_n = '1;
        seg_n = '1;
        tick();
        check_all("mh blank", 1'b0, 1'b0);
        for (int e = 0; e < n; e++) begin
            dig_n = pat;
            seg_n = 8'h40;
            tick();
            check_all($sformatf("multihot %b e%0d", pat, e), e == SD, 1'b0);
        end
    endtask

    initial begin
        logic [7:0]        s;
        logic [DIGITS-1:0] bits;
        logic              xe, xf;
        int                d, n, h;

        model_clear();
        tick();
        tick();
        check_all("power-on reset", 1'b0, 1'b0);
        rst = 1'b0;

        // All 16 legal codes in slot 0, random decimal point.
        for (int k = 0; k < 16; k++) begin
            s = {1'($urandom), codes[k]};
            slot(0, s, 10);
            check($sformatf("legal nibble %0d", k), 32'(value[3:0]), 32'(k));
            check($sformatf("legal ok %0d", k), 32'(digit_ok[0]), 32'd1);
        end

        // Full frame, one frame_valid pulse on the last slot.
        do_reset();
        fvc = 0;
        slot(0, 8'h40, 10);
        slot(1, 8'h79, 10);
        slot(2, 8'h24, 10);
        slot(3, 8'h30, 10);
        check("frame value", 32'(value), 32'h3210);
        check("frame pulses", 32'(fvc), 32'd1);

        // Illegal pattern and multi-hot enable.
        slot(2, 8'h7F, 10);
        check("illegal value kept", 32'(value), 32'h3210);
        check("illegal ok", 32'(digit_ok[2]), 32'd0);
        multihot(4'b1100, 10);

        // Slot one cycle too short, then exactly long enough.
        slot(1, 8'h19, NMIN - 1);
        slot(1, 8'h19, 5);
        slot(1, 8'h12, NMIN);
        check("boundary slot", 32'(value[7:4]), 32'h5);

        // Bounce 79/7F through SAMPLE, then hold 79.
        do_reset();
        h = 10;
        dig_n = '1;
        seg_n = '1;
        tick();
        check_all("bounce blank", 1'b0, 1'b0);
        for (int e = 0; e <= h + STABLE + SD; e++) begin
            dig_n = ~(DIGITS'(1) << 1);
            seg_n = (e < h && e % 2 == 1) ? 8'h7F : 8'h79;
            tick();
            xe = 1'b0;
            xf = 1'b0;
            if (e == h + STABLE + SD) model_commit(1, 8'h79, xe, xf);
            check_all($sformatf("bounce e%0d", e), xe, xf);
        end
        check("bounce value", 32'(value[7:4]), 32'h1);

        // Reset while slot 2 is sampling discards the partial frame.
        slot(0, 8'h40, 10);
        dig_n = '1;
        seg_n = '1;
        tick();
        check_all("pre-rst blank", 1'b0, 1'b0);
        for (int e = 0; e < SETTLE + 2 + SD; e++) begin
            dig_n = ~(DIGITS'(1) << 2);
            seg_n = 8'h24;
            tick();
            check_all($sformatf("partial e%0d", e), 1'b0, 1'b0);
        end
        rst = 1'b1;
        tick();
        model_clear();
        check_all("mid-sample reset", 1'b0, 1'b0);
        rst = 1'b0;
        fvc = 0;
        slot(2, 8'h24, 10);
        slot(3, 8'h30, 10);
        slot(0, 8'h40, 10);
        slot(1, 8'h79, 10);
        check("restart pulses", 32'(fvc), 32'd1);

        // Randomized slots against the model.
        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 9) == 0) begin
                do begin
                    bits = DIGITS'($urandom_range(0, 15));
                end while ($countones(bits) < 2);
                multihot(~bits, $urandom_range(3, 6));
            end else begin
                d = $urandom_range(0, DIGITS - 1);
                n = $urandom_range(NMIN - 2, NMIN + 5);
                if ($urandom_range(0, 7) == 0) s = 8'($urandom);
                else s = {1'($urandom), codes[$urandom_range(0, 15)]};
                slot(d, s, n);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Receive-side companion to the hex-to-seven-segment encoder. Monitors a time-multiplexed, active-low seven-segment bus (shared segment lines plus per-digit enables) and recovers the displayed hex nibble and decimal point for each digit. Each digit's pattern is sampled only after a settle period and must be seen stable for a set number of consecutive samples. Used in self-checking display paths and board-level loopback tests.

## Interface
- DIGITS, 4: number of multiplexed digits; legal range 1..8.
- SETTLE, 4: cycles to wait after a digit enable asserts before sampling; ≥1.
- STABLE, 2: consecutive identical samples required to accept a pattern; ≥1.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- seg_n  in  8  segment bus, active-low; bit7 = DP, bits[6:0] = g..a.
- dig_n  in  DIGITS  digit enables, active-low; a valid scan slot is exactly one bit low.
- value  out  4*DIGITS  decoded nibbles; digit i occupies [4i+3:4i].
- dp  out  DIGITS  decimal point per digit, 1 = lit.
- digit_ok  out  DIGITS  1 = last committed pattern for digit i was a legal hex code.
- frame_valid  out  1  one-cycle pulse when every digit has committed since the last pulse.
- err  out  1  one-cycle pulse on an illegal pattern or a multi-hot dig_n.

## Operation
- Decode map on seg_n[6:0]: 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9, 08→A, 03→b, 46→C, 21→d, 06→E, 0E→F (hex). Any other value is illegal. dp = ~seg_n[7], taken independently of the decode.
- States: IDLE, SETTLE, SAMPLE, COMMIT, HOLD.
- IDLE: if dig_n is one-hot-low, latch the index and dig_n, set cnt=0, go to SETTLE. If two or more bits are low, pulse err once per entry into that condition and stay. If all bits are high, stay.
- SETTLE: if dig_n ≠ latched, go to IDLE. Otherwise, if cnt==SETTLE-1, go to SAMPLE with match=0; else cnt++.
- SAMPLE: if dig_n ≠ latched, go to IDLE. Otherwise capture seg_n into prev, then:
  - match = 1 if match==0 or seg_n≠prev;
  - match = match+1 otherwise.
  - When the updated match reaches STABLE, go to COMMIT.
- COMMIT: always completes, regardless of dig_n.
  - Write value[idx], dp[idx] and digit_ok[idx] from prev.
  - If the pattern is illegal: value[idx] is unchanged, digit_ok[idx]=0, and err pulses.
  - Set seen[idx]. If all seen bits are now set, pulse frame_valid and clear seen.
  - Go to HOLD.
- HOLD: stay until dig_n ≠ latched, then go to IDLE. The same slot is never committed twice.
- Simultaneous err and frame_valid in COMMIT are both allowed.

## Timing
- Reset values: value=0, dp=0, digit_ok=0, frame_valid=0, err=0, seen=0, state=IDLE, cnt=0, match=0.
- Latency: outputs update on edge SETTLE+STABLE+1, counting the first edge that sees one-hot dig_n as edge 0. With the defaults, that is edge 7.
- Minimum slot length for a commit: SETTLE+STABLE+1 cycles of constant dig_n. Shorter slots never commit.
- A seg_n glitch during SAMPLE restarts match at 1; it does not abort the slot.
- Counter widths: cnt is $clog2(SETTLE)+1 bits, match is $clog2(STABLE)+1 bits. Neither counter can wrap.
- rst asserted in any state returns every register to its reset value on that edge; a partially assembled frame is discarded.

## Configuration
- SEG7_SYNC_EN defined: seg_n and dig_n each pass through a 2-flop synchronizer, reset to all-ones, before the FSM. All latencies grow by 2 cycles. Used for asynchronous external pins.
- SEG7_SYNC_EN undefined: inputs feed the FSM directly and are assumed synchronous to clk.

## Test plan
- Legal codes: for DIGITS=4, defaults, drive each of the 16 legal codes in slot 0 for 10 cycles. Required: value[3:0] equals the code's nibble at edge 7, digit_ok[0]=1, no err.
- Full frame: scan digits 0..3 with 40, 79, 24, 30 hex for 10 cycles each. Required: value=16'h3210 and exactly one frame_valid pulse, on slot 3's COMMIT.
- Bounce: in SAMPLE, alternate seg_n 79/7F every cycle, then hold 79. Required: commit occurs 2 cycles after the hold begins, value=1.
- Illegal and multi-hot: seg_n=7F (all segments off) gives an err pulse, digit_ok[idx]=0 and value unchanged. dig_n=4'b1100 gives one err pulse and no commit.
- Short slot and reset: a 5-cycle slot produces no commit. rst asserted during SAMPLE in slot 2 gives all outputs 0 on the next edge, and the frame restarts.
- SEG7_SYNC_EN: repeat the legal-codes scenario. Required: commit at edge 9, values identical.
